// File: rtl/stroke_interp_if.sv
// ---------------------------------------------------------------------------
// stroke_interp_if
//
// Bundles the two handshakes of the stroke interpolator: the cursor-sample
// input from the mouse packetiser and the pixel output towards the
// coordinate FIFO.
//
// Handshake rule (both channels): a transfer happens on a rising CLK edge
// where valid and ready are both 1. A producer holding valid=1 keeps its
// payload stable and does not drop valid until that transfer. The consumer
// may change ready at any time. A producer never waits for ready before it
// raises valid.
//
// Signals:
//   in_valid   upstream -> interp   cursor sample present
//   in_ready   interp -> upstream   interpolator can take a sample
//   in_x       upstream -> interp   sample x (10 bits)
//   in_y       upstream -> interp   sample y (10 bits)
//   in_color   upstream -> interp   sample color (3 bits)
//   in_pen     upstream -> interp   1 = button held, 0 = pen up
//   out_valid  interp -> FIFO       out_pack holds a pixel
//   out_ready  FIFO -> interp       FIFO can take the pixel (~fifo_full)
//   out_pack   interp -> FIFO       {color[22:20], x[19:10], y[9:0]}
//
// Modports:
//   master  the environment side (upstream producer plus FIFO consumer)
//   slave   the interpolator itself
// ---------------------------------------------------------------------------
interface stroke_interp_if;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_x;
  logic [9:0]  in_y;
  logic [2:0]  in_color;
  logic        in_pen;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_pack;

  modport master (
    output in_valid, in_x, in_y, in_color, in_pen, out_ready,
    input  in_ready, out_valid, out_pack
  );

  modport slave (
    input  in_valid, in_x, in_y, in_color, in_pen, out_ready,
    output in_ready, out_valid, out_pack
  );
endinterface

// File: rtl/stroke_interp.sv
// ---------------------------------------------------------------------------
// stroke_interp
//
// Stroke interpolator sitting between the mouse packetiser and the
// coordinate FIFO. Every accepted pen-down cursor sample is joined to the
// previous pen-down sample by a Bresenham line, so fast mouse motion
// produces a continuous stroke of pixels instead of isolated dots.
//
// Parameters:
//   RES_HOR  horizontal resolution; sample x is clamped to RES_HOR-1
//   RES_VER  vertical resolution;   sample y is clamped to RES_VER-1
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   bus        stroke_interp_if.slave (sample input + pixel output)
//   busy       1 whenever the FSM is not in IDLE
//   state_dbg  current FSM state (IDLE=0, SETUP=1, DRAW=2)
//
// Behaviour summary:
//   IDLE   takes one sample. Pen-up forgets the stroke. The first pen-down
//          sample of a stroke becomes a one-pixel segment. A repeat of the
//          previous point is swallowed. Any other point becomes a segment
//          from the previous point; that segment's first pixel is a "skip"
//          pixel, because it was already drawn as the end of the previous
//          segment.
//   SETUP  computes the Bresenham deltas, step directions and initial error.
//   DRAW   presents the current pixel (unless it is the skip pixel). It
//          steps once per transfer and returns to IDLE after the target
//          pixel transfers.
// ---------------------------------------------------------------------------
module stroke_interp #(
  parameter int RES_HOR = 640,
  parameter int RES_VER = 480
) (
  input  logic              CLK,
  input  logic              RST,
  stroke_interp_if.slave    bus,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;

  localparam logic [9:0] X_MAX = 10'(RES_HOR - 1);
  localparam logic [9:0] Y_MAX = 10'(RES_VER - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t             state;
  state_t             state_nxt;

  // End point of the last completed segment of the current stroke.
  logic               have_prev;
  logic [9:0]         prev_x;
  logic [9:0]         prev_y;

  // Segment being drawn.
  logic [9:0]         cur_x;
  logic [9:0]         cur_y;
  logic [9:0]         tgt_x;
  logic [9:0]         tgt_y;
  logic [2:0]         color;
  logic               skip;

  // Bresenham parameters. dx is |delta x|; dy is -|delta y|. sx_pos/sy_pos
  // select +1 (1) or -1 (0) steps.
  logic [10:0]        dx;
  logic signed [11:0] dy;
  logic signed [11:0] err;
  logic               sx_pos;
  logic               sy_pos;

  // -------------------------------------------------------------------------
  // Input side combinational helpers
  // -------------------------------------------------------------------------
  logic [9:0] x_c;
  logic [9:0] y_c;
  logic       accept;
  logic       is_dup;

  always_comb begin
    x_c = (bus.in_x > X_MAX) ? X_MAX : bus.in_x;
    y_c = (bus.in_y > Y_MAX) ? Y_MAX : bus.in_y;
  end

  assign accept = bus.in_valid & bus.in_ready;
  assign is_dup = have_prev && (x_c == prev_x) && (y_c == prev_y);

  // -------------------------------------------------------------------------
  // Segment setup arithmetic (used in SETUP)
  // -------------------------------------------------------------------------
  logic [9:0] adx;
  logic [9:0] ady;

  always_comb begin
    adx = (tgt_x > cur_x) ? (tgt_x - cur_x) : (cur_x - tgt_x);
    ady = (tgt_y > cur_y) ? (tgt_y - cur_y) : (cur_y - tgt_y);
  end

  // -------------------------------------------------------------------------
  // Bresenham step arithmetic (used in DRAW)
  // -------------------------------------------------------------------------
  // e2 = 2*err is one bit wider than err so the doubling cannot overflow.
  // Both axis decisions are taken from the old err, and their err updates
  // are summed, so a diagonal step applies dy and dx in the same cycle.
  logic signed [12:0] e2;
  logic signed [12:0] dx_w;
  logic signed [12:0] dy_w;
  logic signed [11:0] dx_s;
  logic               step_x;
  logic               step_y;
  logic signed [11:0] err_nxt;
  logic [9:0]         cur_x_nxt;
  logic [9:0]         cur_y_nxt;
  logic               at_tgt;

  always_comb begin
    e2        = {err, 1'b0};
    dx_w      = {2'b00, dx};
    dy_w      = {dy[11], dy};
    dx_s      = {1'b0, dx};
    step_x    = (e2 >= dy_w);
    step_y    = (e2 <= dx_w);
    err_nxt   = err + (step_x ? dy : 12'sd0) + (step_y ? dx_s : 12'sd0);
    cur_x_nxt = cur_x;
    cur_y_nxt = cur_y;
    if (step_x) cur_x_nxt = sx_pos ? (cur_x + 10'd1) : (cur_x - 10'd1);
    if (step_y) cur_y_nxt = sy_pos ? (cur_y + 10'd1) : (cur_y - 10'd1);
    at_tgt    = (cur_x == tgt_x) && (cur_y == tgt_y);
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next state, handshake outputs and datapath strobes
  // -------------------------------------------------------------------------
  logic in_ready_c;
  logic out_valid_c;
  logic do_drop;
  logic do_new;
  logic do_conn;
  logic do_setup;
  logic do_step;
  logic do_finish;

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    do_drop     = 1'b0;
    do_new      = 1'b0;
    do_conn     = 1'b0;
    do_setup    = 1'b0;
    do_step     = 1'b0;
    do_finish   = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (accept) begin
          if (!bus.in_pen) begin
            do_drop = 1'b1;
          end else if (!have_prev) begin
            do_new    = 1'b1;
            state_nxt = SETUP;
          end else if (!is_dup) begin
            do_conn   = 1'b1;
            state_nxt = SETUP;
          end
          // A duplicate point leaves everything untouched.
        end
      end
      SETUP: begin
        do_setup  = 1'b1;
        state_nxt = DRAW;
      end
      DRAW: begin
        out_valid_c = ~skip;
        // The skip pixel is never offered, so it advances on its own.
        if (skip || bus.out_ready) begin
          if (at_tgt) begin
            do_finish = 1'b1;
            state_nxt = IDLE;
          end else begin
            do_step = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      have_prev <= 1'b0;
      prev_x    <= '0;
      prev_y    <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      tgt_x     <= '0;
      tgt_y     <= '0;
      color     <= '0;
      skip      <= 1'b0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
      sx_pos    <= 1'b0;
      sy_pos    <= 1'b0;
    end else begin
      if (do_drop) begin
        have_prev <= 1'b0;
      end

      if (do_new) begin
        cur_x <= x_c;
        cur_y <= y_c;
        tgt_x <= x_c;
        tgt_y <= y_c;
        color <= bus.in_color;
        skip  <= 1'b0;
      end

      if (do_conn) begin
        cur_x <= prev_x;
        cur_y <= prev_y;
        tgt_x <= x_c;
        tgt_y <= y_c;
        color <= bus.in_color;
        skip  <= 1'b1;
      end

      if (do_setup) begin
        dx     <= {1'b0, adx};
        dy     <= 12'sd0 - $signed({2'b00, ady});
        err    <= $signed({2'b00, adx}) - $signed({2'b00, ady});
        sx_pos <= (tgt_x > cur_x);
        sy_pos <= (tgt_y > cur_y);
      end

      if (do_step) begin
        err   <= err_nxt;
        cur_x <= cur_x_nxt;
        cur_y <= cur_y_nxt;
        skip  <= 1'b0;
      end

      // The segment end becomes the start of the next connected segment.
      if (do_finish) begin
        prev_x    <= tgt_x;
        prev_y    <= tgt_y;
        have_prev <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  // out_pack reads as zero whenever no pixel is offered.
  assign bus.out_pack  = out_valid_c ? {color, cur_x, cur_y} : 23'd0;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule
